// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath primitives.
package pe_pkg;

  localparam int PE_DATA_W = 24;

  // Select width that never collapses to zero bits for a two-input mux.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One pipeline slot as seen by a debugger or a wider bus.
  typedef struct packed {
    logic [PE_DATA_W-1:0] data;
    logic                 err;
    logic                 vld;
  } pipe_stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One register stage of the mux pipeline: data, error flag, valid and local ready.
module pipe_stage
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  input  logic              in_vld,
  input  logic              rdy_nxt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              out_vld,
  output logic              rdy
);

  logic [DATA_W-1:0] data_p;
  logic              err_p;
  logic              vld_p;

  // An empty stage always accepts, so bubbles collapse behind a stall.
  assign rdy = !vld_p || rdy_nxt;

  // Valid bit: cleared by reset or flush, otherwise follows the upstream valid on a move.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= 1'b0;
    end else if (flush) begin
      vld_p <= 1'b0;
    end else if (rdy) begin
      vld_p <= in_vld;
    end
  end

  // Payload: zeroed on reset, kept through flush, loaded only for real words.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p <= '0;
      err_p  <= 1'b0;
    end else if (!flush && rdy && in_vld) begin
      data_p <= in_data;
      err_p  <= in_err;
    end
  end

  assign out_data = data_p;
  assign out_err  = err_p;
  assign out_vld  = vld_p;

endmodule

// File: rtl/mux_dff_pipe.sv
// NUM_IN-way operand select registered through a DEPTH-stage valid/ready pipeline.
module mux_dff_pipe
  import pe_pkg::*;
#(
  parameter  int DATA_W = PE_DATA_W,
  parameter  int NUM_IN = 4,
  parameter  int DEPTH  = 2,
  localparam int SEL_W  = clog2_min1(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] mux_data;
  logic              mux_err;

  // Index 0 is the mux output; index k+1 is the output of stage k.
  logic [DATA_W-1:0] data_p [DEPTH+1];
  logic              err_p  [DEPTH+1];
  logic [DEPTH:0]    vld_p;
  logic [DEPTH-1:0]  rdy_st;
  logic              unused_rdy;

  // Word select with range check; an out-of-range select yields zero data and err.
  always_comb begin
    mux_data = '0;
    mux_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_data = in_data[i*DATA_W +: DATA_W];
        mux_err  = 1'b0;
      end
    end
  end

  assign data_p[0] = mux_data;
  assign err_p[0]  = mux_err;
  assign vld_p[0]  = in_valid;

  genvar k;
  for (k = 0; k < DEPTH; k++) begin : g_stage
    logic rdy_nxt;

    // Downstream ready is derived from the registered valids, so the chain has no comb loop:
    // stage k+1 can take a word if the output drains or any stage beyond k is empty.
    if (k == DEPTH-1) begin : g_last
      assign rdy_nxt = out_ready;
    end else begin : g_mid
      assign rdy_nxt = out_ready || !(&vld_p[DEPTH:k+2]);
    end

    pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_data  (data_p[k]),
      .in_err   (err_p[k]),
      .in_vld   (vld_p[k]),
      .rdy_nxt  (rdy_nxt),
      .out_data (data_p[k+1]),
      .out_err  (err_p[k+1]),
      .out_vld  (vld_p[k+1]),
      .rdy      (rdy_st[k])
    );
  end

  // Only the first stage's ready faces upstream; the rest are internal.
  assign unused_rdy = ^rdy_st;

  // Flush accepts (and discards) the offered word; reset refuses it.
  assign in_ready = rst ? 1'b0 : (flush ? 1'b1 : rdy_st[0]);

  assign out_data  = data_p[DEPTH];
  assign out_err   = err_p[DEPTH];
  assign out_valid = vld_p[DEPTH];

endmodule

// File: tb/tb_mux_dff_pipe.sv
// Randomised bench for mux_dff_pipe: three builds driven side by side against a queue model.
module tb_mux_dff_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [95:0] in_data   [3];
  logic [1:0]  sel       [3];
  logic        in_valid  [3];
  logic        out_ready [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_err   [3];
  logic [23:0] out_data  [3];

  always #5 clk = ~clk;

  // Build 0: defaults (4 inputs, depth 2).
  mux_dff_pipe #(.DATA_W(24), .NUM_IN(4), .DEPTH(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .sel(sel[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .flush(flush),
    .out_data(out_data[0]), .out_err(out_err[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]));

  // Build 1: 3 inputs, so select value 3 is out of range.
  mux_dff_pipe #(.DATA_W(24), .NUM_IN(3), .DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data[1][71:0]), .sel(sel[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .flush(flush),
    .out_data(out_data[1]), .out_err(out_err[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]));

  // Build 2: 2 inputs, single stage.
  mux_dff_pipe #(.DATA_W(24), .NUM_IN(2), .DEPTH(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(in_data[2][47:0]), .sel(sel[2][0:0]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .flush(flush),
    .out_data(out_data[2]), .out_err(out_err[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]));

  typedef struct {
    logic [23:0] data;
    logic        err;
    int          age;
  } ent_t;

  ent_t        mq     [3][$];
  logic [23:0] last_d [3];
  logic        last_e [3];
  bit          armed = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic int ni(input int d);
    return (d == 0) ? 4 : (d == 1) ? 3 : 2;
  endfunction

  function automatic int dp(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic int sw(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs against the model, then advance the model across the next edge.
  task automatic step();
    #1;
    for (int d = 0; d < 3; d++) begin
      bit          ev;
      bit          er;
      logic [23:0] ed;
      logic        ee;
      ev = (mq[d].size() > 0) && (mq[d][0].age >= dp(d));
      er = !rst && (flush || out_ready[d] || (mq[d].size() < dp(d)));
      ed = ev ? mq[d][0].data : last_d[d];
      ee = ev ? mq[d][0].err  : last_e[d];
      if (armed) begin
        check($sformatf("out_valid[%0d]", d), 32'(out_valid[d]), 32'(ev));
        check($sformatf("in_ready[%0d]", d),  32'(in_ready[d]),  32'(er));
        check($sformatf("out_data[%0d]", d),  32'(out_data[d]),  32'(ed));
        check($sformatf("out_err[%0d]", d),   32'(out_err[d]),   32'(ee));
      end
      if (ev) begin
        last_d[d] = ed;
        last_e[d] = ee;
      end
      if (rst) begin
        mq[d].delete();
        last_d[d] = '0;
        last_e[d] = 1'b0;
      end else if (flush) begin
        mq[d].delete();
      end else begin
        if (ev && out_ready[d]) void'(mq[d].pop_front());
        if (er && in_valid[d]) begin
          int   s;
          ent_t e;
          s = int'(sel[d]) & ((1 << sw(d)) - 1);
          if (s < ni(d)) begin
            e.data = in_data[d][s*24 +: 24];
            e.err  = 1'b0;
          end else begin
            e.data = '0;
            e.err  = 1'b1;
          end
          e.age = 0;
          mq[d].push_back(e);
        end
        for (int i = 0; i < mq[d].size(); i++) mq[d][i].age++;
      end
    end
    if (rst) armed = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_all(input logic v, input logic r, input logic [1:0] s);
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = v;
      out_ready[d] = r;
      sel[d]       = s;
    end
  endtask

  task automatic words(input logic [23:0] w0, input logic [23:0] w1,
                       input logic [23:0] w2, input logic [23:0] w3);
    for (int d = 0; d < 3; d++) in_data[d] = {w3, w2, w1, w0};
  endtask

  task automatic rnd_words();
    for (int d = 0; d < 3; d++) in_data[d] = {$urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    set_all(1'b0, 1'b1, 2'd0);
    words(24'h0, 24'h0, 24'h0, 24'h0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Reset then stream the same word set with select 2.
    words(24'h11, 24'h22, 24'h33, 24'h44);
    set_all(1'b1, 1'b1, 2'd2);
    repeat (6) step();

    // Select sweep, back-to-back.
    words(24'hA0, 24'hA1, 24'hA2, 24'hA3);
    for (int s = 0; s < 4; s++) begin
      set_all(1'b1, 1'b1, 2'(s));
      step();
    end
    set_all(1'b0, 1'b1, 2'd0);
    repeat (4) step();

    // Back-pressure with a bubble, then drain.
    set_all(1'b1, 1'b0, 2'd1);
    rnd_words(); step();
    set_all(1'b0, 1'b0, 2'd1);
    step();
    set_all(1'b1, 1'b0, 2'd0);
    rnd_words(); step();
    rnd_words(); step();
    rnd_words(); step();
    rnd_words(); step();
    set_all(1'b0, 1'b1, 2'd0);
    repeat (5) step();

    // Flush with words in flight, then a fresh word.
    set_all(1'b1, 1'b1, 2'd3);
    rnd_words(); step();
    rnd_words(); step();
    flush = 1'b1;
    rnd_words(); step();
    flush = 1'b0;
    set_all(1'b1, 1'b1, 2'd1);
    rnd_words(); step();
    set_all(1'b0, 1'b1, 2'd0);
    repeat (4) step();

    // Reset with words in flight, then a fresh word.
    set_all(1'b1, 1'b1, 2'd2);
    rnd_words(); step();
    rnd_words(); step();
    rst = 1'b1;
    rnd_words(); step();
    rst = 1'b0;
    rnd_words(); step();
    set_all(1'b0, 1'b1, 2'd0);
    repeat (4) step();

    // Full-rate stream with out_ready toggling every cycle.
    for (int i = 0; i < 24; i++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = 1'b1;
        out_ready[d] = i[0];
        sel[d]       = 2'($urandom_range(0, 3));
      end
      rnd_words();
      step();
    end

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        out_ready[d] = ($urandom_range(0, 4) < 3);
        sel[d]       = 2'($urandom_range(0, 3));
      end
      flush = ($urandom_range(0, 29) == 0);
      rst   = ($urandom_range(0, 79) == 0);
      rnd_words();
      step();
    end
    rst   = 1'b0;
    flush = 1'b0;
    set_all(1'b0, 1'b1, 2'd0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_dff_pipe.md
Name: mux_dff_pipe

Overview:
- Parametrised successor to the two-input mux-plus-enabled-register PE primitive.
- Selects one of NUM_IN input words and carries the selection through a DEPTH-stage pipeline.
- Flow control is valid/ready with bubble collapsing, plus synchronous flush and an out-of-range select flag.
- Used in the PE datapath wherever operand selection must be registered and back-pressured.

Parameters:
- DATA_W, 24, width of each input word and of out_data.
- NUM_IN, 4, number of selectable inputs; must be >= 2.
- DEPTH, 2, number of register stages; must be >= 1.
- SEL_W, $clog2(NUM_IN), width of sel; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_IN*DATA_W  packed inputs; word i = in_data[i*DATA_W +: DATA_W].
- sel  in  SEL_W  input select, sampled with in_valid.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts a word this cycle.
- flush  in  1  synchronous pipeline clear.
- out_data  out  DATA_W  last-stage data.
- out_err  out  1  last-stage word was captured with sel >= NUM_IN.
- out_valid  out  1  last-stage valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Per-stage state, k = 0..DEPTH-1: data_k[DATA_W], err_k, vld_k.
- Reset (rst=1 at the edge): all vld_k=0, data_k=0, err_k=0. Therefore out_valid=0, out_data=0, out_err=0.
- in_ready is 0 while rst is high.
- rst has priority over flush and over any transfer.
- Ready chain:
  - rdy_DEPTH = out_ready.
  - rdy_k = !vld_k || rdy_{k+1}.
  - in_ready = rdy_0, a combinational path from out_ready. This is accepted at the depths used.
- Stage 0 load: when rdy_0, vld_0 <= in_valid.
  - If in_valid: data_0 <= word[sel] and err_0 <= 0.
  - If sel >= NUM_IN: data_0 <= 0 and err_0 <= 1.
- Stage k > 0 load: when rdy_k, vld_k <= vld_{k-1}; data_k/err_k <= data_{k-1}/err_{k-1} when vld_{k-1}.
- When rdy_k=0, stage k holds data, err and vld.
- Data registers load only when the incoming valid is 1, so they do not toggle on bubbles (power requirement).
- Latency: an accepted word appears on out_data with out_valid=1 exactly DEPTH cycles after the acceptance edge, provided out_ready stays high.
- Throughput: one word per cycle with no stall. Bubbles collapse: an empty stage accepts even while its successor is stalled.
- Full: all vld_k=1 and out_ready=0 gives in_ready=0. Nothing is lost and no data changes.
- Simultaneous out_ready=1 and in_valid=1 when full: the shift and the accept happen in the same cycle.
- flush=1 (rst=0): all vld_k <= 0 next cycle, data/err retained. in_ready=1 during flush, but the input word is discarded. out_valid=0 the cycle after.
- Reset or flush mid-stream: in-flight words are dropped. There is no partial output.
- Handshake rules:
  - out_data/out_err are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on rst or flush.
- sel is don't-care when in_valid=0.

Decomposition:
- Shared package pe_pkg holds:
  - the DATA_W default constant;
  - a function clog2_min1 (returns 1 for NUM_IN=2 edge safety);
  - typedef pipe_stage_t {data, err, vld}, parametrised via DATA_W.
- Sub-module pipe_stage holds one stage: registers plus local ready. It is generated DEPTH times.
- The NUM_IN-way mux with range check stays inline in the top.

Test Plan:
- Reset then stream: rst=1 for 2 cycles, then in_data words {0x11,0x22,0x33,0x44}, sel=2, in_valid=1, out_ready=1 (defaults). Expect out_data=0x33, out_valid=1 exactly 2 cycles after first accept, err=0. Before that, out_valid=0 and out_data=0.
- Select sweep: sel=0,1,2,3 on consecutive cycles with words 0xA0..0xA3. Expect out_data sequence 0xA0,0xA1,0xA2,0xA3 back-to-back with no bubbles.
- Back-pressure and bubble collapse:
  - Accept 1 word, then in_valid=0 for 1 cycle, then 2 more words, out_ready=0 throughout.
  - Expect in_ready=0 after 2 words are held, and out_data stable.
  - On out_ready=1, expect 3 words out in order, nothing dropped or duplicated.
- Out of range: NUM_IN=3, SEL_W=2, sel=3, in_valid=1. Expect out_data=0 and out_err=1 for that word only; the next word with sel=1 gives out_err=0.
- Flush and reset mid-stream:
  - With 2 words in flight, flush=1 for 1 cycle; expect out_valid=0 next cycle, and a new word after that emerges with normal 2-cycle latency.
  - Repeat with rst=1 instead; expect out_data=0 as well.
- DEPTH=1, NUM_IN=2 build: full-rate stream with out_ready toggling every cycle. Expect every accepted word output exactly once, in order, latency 1.
